// File: rtl/md_unit_if.sv
// Operand/result bundle between the E-stage datapath and the multiply/divide unit.
// The slave modport is the unit itself; the master modport is the pipeline side.
interface md_unit_if;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        start;
    logic [31:0] hi;
    logic [31:0] lo;

    modport slave (
        input  md_op,
        input  a,
        input  b,
        input  flush,
        output busy,
        output start,
        output hi,
        output lo
    );

    modport master (
        output md_op,
        output a,
        output b,
        output flush,
        input  busy,
        input  start,
        input  hi,
        input  lo
    );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// The result is computed at issue, held in temporaries, and committed when the busy countdown expires.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset,
    md_unit_if.slave  bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          is_md_s, is_mult_s, start_s;
    logic [63:0]   prod_s;
    logic [31:0]   mag_a_s, mag_b_s, quo_s, rem_s;
    logic [31:0]   res_hi_s, res_lo_s;

    assign is_md_s   = (bus.md_op >= OP_MULT) && (bus.md_op <= OP_DIVU);
    assign is_mult_s = (bus.md_op == OP_MULT) || (bus.md_op == OP_MULTU);
    assign start_s   = is_md_s && !busy_q && !bus.flush;

    // Result datapath; divide by zero reproduces the current HI/LO so completion leaves them unchanged.
    always_comb begin
        prod_s   = 64'd0;
        mag_a_s  = bus.a;
        mag_b_s  = bus.b;
        quo_s    = 32'd0;
        rem_s    = 32'd0;
        res_hi_s = hi_q;
        res_lo_s = lo_q;
        case (bus.md_op)
            OP_MULT: begin
                prod_s   = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
                res_hi_s = prod_s[63:32];
                res_lo_s = prod_s[31:0];
            end
            OP_MULTU: begin
                prod_s   = {32'd0, bus.a} * {32'd0, bus.b};
                res_hi_s = prod_s[63:32];
                res_lo_s = prod_s[31:0];
            end
            OP_DIV: begin
                // Divide magnitudes, then restore signs; avoids the INT_MIN / -1 overflow corner.
                mag_a_s = bus.a[31] ? (32'd0 - bus.a) : bus.a;
                mag_b_s = bus.b[31] ? (32'd0 - bus.b) : bus.b;
                if (bus.b != 32'd0) begin
                    quo_s    = mag_a_s / mag_b_s;
                    rem_s    = mag_a_s % mag_b_s;
                    res_lo_s = (bus.a[31] ^ bus.b[31]) ? (32'd0 - quo_s) : quo_s;
                    res_hi_s = bus.a[31] ? (32'd0 - rem_s) : rem_s;
                end else begin
                    res_hi_s = hi_q;
                    res_lo_s = lo_q;
                end
            end
            OP_DIVU: begin
                if (bus.b != 32'd0) begin
                    quo_s    = mag_a_s / mag_b_s;
                    rem_s    = mag_a_s % mag_b_s;
                    res_lo_s = quo_s;
                    res_hi_s = rem_s;
                end else begin
                    res_hi_s = hi_q;
                    res_lo_s = lo_q;
                end
            end
            default: begin
                res_hi_s = hi_q;
                res_lo_s = lo_q;
            end
        endcase
    end

    // Next-state logic: ops are ignored while busy, and flush only gates new issues.
    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_tmp_d = hi_tmp_q;
        lo_tmp_d = lo_tmp_q;
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        if (busy_q) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                hi_d   = hi_tmp_q;
                lo_d   = lo_tmp_q;
                busy_d = 1'b0;
            end else begin
                busy_d = 1'b1;
            end
        end else if (start_s) begin
            hi_tmp_d = res_hi_s;
            lo_tmp_d = res_lo_s;
            busy_d   = 1'b1;
            cnt_d    = is_mult_s ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        end else if (!bus.flush && (bus.md_op == OP_MTHI)) begin
            hi_d = bus.a;
        end else if (!bus.flush && (bus.md_op == OP_MTLO)) begin
            lo_d = bus.a;
        end else begin
            busy_d = 1'b0;
        end
    end

    // State registers with synchronous reset that discards any pending result.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            hi_tmp_q <= 32'd0;
            lo_tmp_q <= 32'd0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_tmp_q <= hi_tmp_d;
            lo_tmp_q <= lo_tmp_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.start = start_s;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Directed and randomized checks of md_unit against an arithmetic reference model of HI/LO.
module tb_md_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [31:0] m_hi, m_lo;

    md_unit_if mif ();

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, input logic fl);
        mif.md_op = op;
        mif.a     = x;
        mif.b     = y;
        mif.flush = fl;
        #1;
    endtask

    // Reference model: architectural effect of one accepted operation.
    task automatic model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = $signed(x);
        sy = $signed(y);
        case (op)
            3'd1: begin p = sx * sy; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd2: begin p = {32'd0, x} * {32'd0, y}; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd3: if (y != 32'd0) begin
                q = sx / sy; r = sx % sy; m_lo = q[31:0]; m_hi = r[31:0];
            end
            3'd4: if (y != 32'd0) begin m_lo = x / y; m_hi = x % y; end
            3'd5: m_hi = x;
            3'd6: m_lo = x;
            default: ;
        endcase
    endtask

    // Issue a mult/div in the current cycle and follow it to completion (ends in cycle N+1).
    task automatic run_md(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        int n;
        logic [31:0] old_hi, old_lo;
        n = (op == 3'd1 || op == 3'd2) ? MC : DC;
        old_hi = m_hi;
        old_lo = m_lo;
        drive(op, x, y, 1'b0);
        chk("start", {31'd0, mif.start}, 32'd1);
        model(op, x, y);
        for (int c = 1; c <= n; c++) begin
            tick();
            drive(3'd0, 32'd0, 32'd0, 1'b0);
            chk("busy_hi", {31'd0, mif.busy}, 32'd1);
            chk("hold_hi", mif.hi, old_hi);
            chk("hold_lo", mif.lo, old_lo);
        end
        tick();
        chk("busy_done", {31'd0, mif.busy}, 32'd0);
        chk("res_hi", mif.hi, m_hi);
        chk("res_lo", mif.lo, m_lo);
    endtask

    task automatic run_mt(input logic [2:0] op, input logic [31:0] x);
        drive(op, x, 32'd0, 1'b0);
        chk("mt_start", {31'd0, mif.start}, 32'd0);
        model(op, x, 32'd0);
        tick();
        drive(3'd0, 32'd0, 32'd0, 1'b0);
        chk("mt_busy", {31'd0, mif.busy}, 32'd0);
        chk("mt_hi", mif.hi, m_hi);
        chk("mt_lo", mif.lo, m_lo);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] x, y;
        reset = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        drive(3'd0, 32'd0, 32'd0, 1'b0);
        tick(); tick();
        chk("rst_busy", {31'd0, mif.busy}, 32'd0);
        chk("rst_hi", mif.hi, 32'd0);
        chk("rst_lo", mif.lo, 32'd0);
        chk("rst_start", {31'd0, mif.start}, 32'd0);
        reset = 1'b0;
        tick();

        // Reset in cycle 4 of a divide discards everything.
        run_mt(3'd5, 32'h0000_1111);
        run_mt(3'd6, 32'h0000_2222);
        drive(3'd3, 32'd100, 32'd7, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            drive(3'd0, 32'd0, 32'd0, 1'b0);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        chk("rstmid_busy", {31'd0, mif.busy}, 32'd0);
        chk("rstmid_hi", mif.hi, 32'd0);
        chk("rstmid_lo", mif.lo, 32'd0);
        for (int c = 0; c < DC + 2; c++) begin
            tick();
            chk("rstmid_hold_hi", mif.hi, 32'd0);
            chk("rstmid_hold_lo", mif.lo, 32'd0);
        end

        // Directed arithmetic corners, issued back to back.
        run_md(3'd1, 32'hFFFF_FFFF, 32'd2);
        chk("mult_hi", mif.hi, 32'hFFFF_FFFF);
        chk("mult_lo", mif.lo, 32'hFFFF_FFFE);
        run_md(3'd2, 32'hFFFF_FFFF, 32'd2);
        chk("multu_hi", mif.hi, 32'h0000_0001);
        chk("multu_lo", mif.lo, 32'hFFFF_FFFE);
        run_md(3'd3, 32'hFFFF_FFF9, 32'd2);
        chk("div_hi", mif.hi, 32'hFFFF_FFFF);
        chk("div_lo", mif.lo, 32'hFFFF_FFFD);
        run_md(3'd4, 32'd7, 32'd2);
        chk("divu_hi", mif.hi, 32'd1);
        chk("divu_lo", mif.lo, 32'd3);
        run_md(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("divovf_hi", mif.hi, 32'd0);
        chk("divovf_lo", mif.lo, 32'h8000_0000);

        // Divide by zero leaves HI/LO intact.
        run_mt(3'd5, 32'h0000_1234);
        run_mt(3'd6, 32'h0000_5678);
        run_md(3'd3, 32'd99, 32'd0);
        chk("dz_hi", mif.hi, 32'h0000_1234);
        chk("dz_lo", mif.lo, 32'h0000_5678);
        run_md(3'd4, 32'd99, 32'd0);
        chk("dzu_hi", mif.hi, 32'h0000_1234);

        // Flush squashes an E-stage op.
        drive(3'd1, 32'd3, 32'd4, 1'b1);
        chk("flush_start", {31'd0, mif.start}, 32'd0);
        tick();
        drive(3'd6, 32'h0000_AAAA, 32'd0, 1'b1);
        chk("flush_busy", {31'd0, mif.busy}, 32'd0);
        chk("flush_hi", mif.hi, 32'h0000_1234);
        tick();
        drive(3'd0, 32'd0, 32'd0, 1'b0);
        chk("flush_lo", mif.lo, 32'h0000_5678);

        // Flush and an injected mthi during busy are ignored.
        drive(3'd1, 32'd3, 32'd5, 1'b0);
        model(3'd1, 32'd3, 32'd5);
        tick(); drive(3'd0, 32'd0, 32'd0, 1'b0);
        tick(); drive(3'd0, 32'd0, 32'd0, 1'b1);
        chk("inj_busy2", {31'd0, mif.busy}, 32'd1);
        tick(); drive(3'd5, 32'h0000_DEAD, 32'd0, 1'b0);
        chk("inj_start", {31'd0, mif.start}, 32'd0);
        tick(); drive(3'd0, 32'd0, 32'd0, 1'b0);
        chk("inj_hold_hi", mif.hi, 32'h0000_1234);
        tick();
        chk("inj_busy5", {31'd0, mif.busy}, 32'd1);
        tick();
        chk("inj_busy6", {31'd0, mif.busy}, 32'd0);
        chk("inj_hi", mif.hi, 32'd0);
        chk("inj_lo", mif.lo, 32'd15);

        // Randomized mix against the model.
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(1, 6));
            x  = $urandom;
            case ($urandom_range(0, 3))
                0: y = 32'd0;
                1: y = 32'($urandom_range(1, 20));
                2: y = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
                default: y = $urandom;
            endcase
            if (op >= 3'd5) run_mt(op, x);
            else run_md(op, x, y);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
